sys_array_arbiter: RTL and testbench
====================================

SYS_ARRAY_ARBITER -- requirements
Module: sys_array_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand element width.
REQ-002 SHALL have parameters ARRAY_A_W, ARRAY_A_L, ARRAY_W_W, ARRAY_W_L, default 4 each, matrix dimensions matching the fetcher.
REQ-003 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-004 SHALL have parameter TIMEOUT, default 64, maximum cycles waited for fetcher ready.
REQ-005 clk  input  1  clock; reset_n  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester job request.
REQ-007 req_ready  output  NUM_REQ  one-hot acceptance pulse.
REQ-008 req_reuse_w  input  NUM_REQ  requester asks to keep previously loaded weights.
REQ-009 req_a  input  NUM_REQ x ARRAY_A_W x ARRAY_A_L x DATA_WIDTH signed  per-requester input matrix.
REQ-010 req_w  input  NUM_REQ x ARRAY_W_W x ARRAY_W_L x DATA_WIDTH signed  per-requester weight matrix.
REQ-011 resp_valid  output  NUM_REQ  one-hot result-valid to job owner.
REQ-012 resp_ready  input  NUM_REQ  per-requester result acceptance.
REQ-013 resp_data  output  ARRAY_A_W x ARRAY_W_L x 2*DATA_WIDTH signed  shared result bus.
REQ-014 resp_timeout  output  1  sticky error, set on fetcher timeout.
REQ-015 f_weights_load, f_start_comp  output  1 each  fetcher controls; f_input_data, f_weights  output  fetcher operands.
REQ-016 f_ready  input  1; f_out_data  input  ARRAY_A_W x ARRAY_W_L x 2*DATA_WIDTH  fetcher result.

Function
REQ-017 FSM states SHALL be IDLE, LOAD_W, START, WAIT, RESP.
REQ-018 IDLE: if any req_valid, grant first asserted requester at or after priority pointer (round-robin, wrap NUM_REQ-1 -> 0); pulse req_ready[g] one cycle; capture req_a[g], req_w[g], req_reuse_w[g] into registers.
REQ-019 Transition from IDLE SHALL go to START if captured reuse=1 AND g equals last-weights-owner AND weights_valid=1; else LOAD_W.
REQ-020 LOAD_W: f_weights_load=1 for exactly one cycle with f_weights = captured weights; set last-weights-owner=g, weights_valid=1; next START.
REQ-021 START: f_start_comp=1 for exactly one cycle; f_input_data driven from captured registers from START through end of WAIT; next WAIT.
REQ-022 WAIT: timeout counter cleared on entry, increments each cycle; on f_ready=1 capture f_out_data into result register, go RESP.
REQ-023 WAIT: counter reaching TIMEOUT without f_ready SHALL set resp_timeout, clear weights_valid, go IDLE without resp_valid.
REQ-024 RESP: resp_valid[g]=1, resp_data = result register, held stable until resp_ready[g]=1; then advance pointer to g+1 (wrap), go IDLE.
REQ-025 resp_ready of non-granted requesters SHALL be ignored; req_valid changes during non-IDLE states SHALL be ignored.
REQ-026 Minimum job latency (req_ready pulse to resp_valid) SHALL be 3 cycles plus fetcher latency; no back-to-back acceptance before RESP completes (one job in flight).
REQ-027 Fetcher control outputs SHALL be registered; f_weights_load and f_start_comp never asserted in the same cycle.
REQ-028 resp_data SHALL be zero whenever resp_valid is all-zero.

Reset
REQ-029 On reset_n=0 at clk edge: state=IDLE, pointer=0, weights_valid=0, req_ready=0, resp_valid=0, resp_timeout=0, f_weights_load=0, f_start_comp=0, result and captured registers zero.
REQ-030 Reset mid-job SHALL abandon the job silently; no resp_valid after reset release until a new acceptance.

Structure
REQ-031 State enum, matrix typedefs (A, W, result) and width constants SHALL live in shared package sys_array_pkg.
REQ-032 Round-robin grant logic SHALL be one sub-module rr_arbiter (NUM_REQ parameter, req, pointer in, one-hot grant out).

Verification
REQ-033 Single job: requester 0, A=identity, W=all 2, reuse=0 -> one f_weights_load pulse, one f_start_comp, resp_data all 2 on resp_valid[0].
REQ-034 Fairness: req_valid=4'b1111 held -> grants in order 0,1,2,3,0, each resp acknowledged.
REQ-035 Weight reuse: requester 2 twice, second with reuse=1 -> no f_weights_load on second job; result correct with W unchanged; reuse=1 from requester 1 after owner 2 -> LOAD_W taken.
REQ-036 Backpressure: resp_ready low 10 cycles -> resp_valid and resp_data stable, no new req_ready.
REQ-037 Timeout: f_ready tied 0, TIMEOUT=64 -> resp_timeout set 64 cycles after WAIT entry, FSM in IDLE, next job performs LOAD_W.
REQ-038 Reset in WAIT -> all outputs at reset values, no stale resp_valid afterwards.

Source files
------------

// File: rtl/sys_array_pkg.sv
// Shared types and default sizes for the systolic-array job arbiter.
// Matrix typedefs describe the default-sized operands exchanged with the fetcher.
package sys_array_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int A_W_DEF        = 4;
    localparam int A_L_DEF        = 4;
    localparam int W_W_DEF        = 4;
    localparam int W_L_DEF        = 4;
    localparam int NUM_REQ_DEF    = 4;
    localparam int TIMEOUT_DEF    = 64;
    localparam int RES_WIDTH_DEF  = 2 * DATA_WIDTH_DEF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        START  = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } state_t;

    typedef logic signed [A_W_DEF-1:0][A_L_DEF-1:0][DATA_WIDTH_DEF-1:0] a_mat_t;
    typedef logic signed [W_W_DEF-1:0][W_L_DEF-1:0][DATA_WIDTH_DEF-1:0] w_mat_t;
    typedef logic signed [A_W_DEF-1:0][W_L_DEF-1:0][RES_WIDTH_DEF-1:0]  res_mat_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request at or after the pointer, wrapping to 0.
// Purely combinational; the caller owns and advances the pointer.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_grant
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] w_mask;
    logic [NUM_REQ-1:0] w_req_hi;
    logic [NUM_REQ-1:0] w_pick;

    // NOTE: default assigned before the loop so no path leaves w_mask unassigned (no latch).
    always_comb begin
        w_mask = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_mask[j] = (PTR_W'(j) >= i_ptr);
        end
    end

    // Requests at/after the pointer win; otherwise wrap around to the lowest index.
    assign w_req_hi = i_req & w_mask;
    assign w_pick   = (|w_req_hi) ? w_req_hi : i_req;
    assign o_grant  = w_pick & (~w_pick + NUM_REQ'(1));

endmodule

// File: rtl/sys_array_arbiter.sv
// Multiplexes NUM_REQ requesters onto one systolic-array fetcher, one job in flight,
// with round-robin fairness, optional weight reuse and a fetcher-ready timeout.
module sys_array_arbiter
    import sys_array_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ARRAY_A_W  = A_W_DEF,
    parameter int ARRAY_A_L  = A_L_DEF,
    parameter int ARRAY_W_W  = W_W_DEF,
    parameter int ARRAY_W_L  = W_L_DEF,
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                                                         clk,
    input  logic                                                         reset_n,
    input  logic        [NUM_REQ-1:0]                                    req_valid,
    output logic        [NUM_REQ-1:0]                                    req_ready,
    input  logic        [NUM_REQ-1:0]                                    req_reuse_w,
    input  logic signed [NUM_REQ-1:0][ARRAY_A_W-1:0][ARRAY_A_L-1:0][DATA_WIDTH-1:0] req_a,
    input  logic signed [NUM_REQ-1:0][ARRAY_W_W-1:0][ARRAY_W_L-1:0][DATA_WIDTH-1:0] req_w,
    output logic        [NUM_REQ-1:0]                                    resp_valid,
    input  logic        [NUM_REQ-1:0]                                    resp_ready,
    output logic signed [ARRAY_A_W-1:0][ARRAY_W_L-1:0][2*DATA_WIDTH-1:0] resp_data,
    output logic                                                         resp_timeout,
    output logic                                                         f_weights_load,
    output logic                                                         f_start_comp,
    output logic signed [ARRAY_A_W-1:0][ARRAY_A_L-1:0][DATA_WIDTH-1:0]   f_input_data,
    output logic signed [ARRAY_W_W-1:0][ARRAY_W_L-1:0][DATA_WIDTH-1:0]   f_weights,
    input  logic                                                         f_ready,
    input  logic signed [ARRAY_A_W-1:0][ARRAY_W_L-1:0][2*DATA_WIDTH-1:0] f_out_data
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t                r_state;
    state_t                w_state_next;

    logic [NUM_REQ-1:0]    w_grant;
    logic [PTR_W-1:0]      w_gnt_idx;
    logic                  w_accept;
    logic                  w_reuse_hit;
    logic                  w_timeout_hit;
    logic                  w_resp_done;

    logic [PTR_W-1:0]      r_ptr;
    logic [PTR_W-1:0]      r_gnt_idx;
    logic [NUM_REQ-1:0]    r_gnt_oh;
    logic [PTR_W-1:0]      r_owner;
    logic                  r_weights_valid;
    logic [CNT_W-1:0]      r_cnt;

    logic [NUM_REQ-1:0]    r_req_ready;
    logic [NUM_REQ-1:0]    r_resp_valid;
    logic                  r_resp_timeout;
    logic                  r_f_weights_load;
    logic                  r_f_start_comp;

    logic signed [ARRAY_A_W-1:0][ARRAY_A_L-1:0][DATA_WIDTH-1:0]   r_a;
    logic signed [ARRAY_W_W-1:0][ARRAY_W_L-1:0][DATA_WIDTH-1:0]   r_w;
    logic signed [ARRAY_A_W-1:0][ARRAY_W_L-1:0][2*DATA_WIDTH-1:0] r_result;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant)
    );

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) w_gnt_idx = PTR_W'(i);
        end
    end

    // Reuse is only safe if this requester's weights are still the ones in the array.
    assign w_reuse_hit = req_reuse_w[w_gnt_idx] && (w_gnt_idx == r_owner) && r_weights_valid;

    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_timeout_hit = 1'b0;
        w_resp_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = w_reuse_hit ? START : LOAD_W;
                end
            end
            LOAD_W: w_state_next = START;
            START:  w_state_next = WAIT;
            WAIT: begin
                if (f_ready) begin
                    w_state_next = RESP;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_timeout_hit = 1'b1;
                    w_state_next  = IDLE;
                end
            end
            RESP: begin
                if (|(resp_ready & r_gnt_oh)) begin
                    w_resp_done  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    // NOTE: the wide operand/result registers are reset as well, so no stale data
    // can reach the fetcher or resp_data after a reset abandons a job.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ptr            <= '0;
            r_gnt_idx        <= '0;
            r_gnt_oh         <= '0;
            r_owner          <= '0;
            r_weights_valid  <= 1'b0;
            r_cnt            <= '0;
            r_req_ready      <= '0;
            r_resp_valid     <= '0;
            r_resp_timeout   <= 1'b0;
            r_f_weights_load <= 1'b0;
            r_f_start_comp   <= 1'b0;
            r_a              <= '0;
            r_w              <= '0;
            r_result         <= '0;
        end else begin
            // Control outputs are registered off the next state so each pulse aligns with its state.
            r_req_ready      <= w_accept ? w_grant : '0;
            r_f_weights_load <= (w_state_next == LOAD_W);
            r_f_start_comp   <= (w_state_next == START);
            r_resp_valid     <= (w_state_next == RESP) ? r_gnt_oh : '0;

            if (w_accept) begin
                r_gnt_idx <= w_gnt_idx;
                r_gnt_oh  <= w_grant;
                r_a       <= req_a[w_gnt_idx];
                r_w       <= req_w[w_gnt_idx];
            end

            if (r_state == LOAD_W) begin
                r_owner         <= r_gnt_idx;
                r_weights_valid <= 1'b1;
            end

            r_cnt <= (r_state == WAIT) ? r_cnt + CNT_W'(1) : '0;

            if (r_state == WAIT && f_ready) r_result <= f_out_data;

            if (w_timeout_hit) begin
                r_resp_timeout  <= 1'b1;
                r_weights_valid <= 1'b0;
            end

            if (w_resp_done) begin
                r_ptr <= (r_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : r_gnt_idx + PTR_W'(1);
            end
        end
    end

    assign req_ready      = r_req_ready;
    assign resp_valid     = r_resp_valid;
    assign resp_timeout   = r_resp_timeout;
    assign f_weights_load = r_f_weights_load;
    assign f_start_comp   = r_f_start_comp;
    assign f_input_data   = r_a;
    assign f_weights      = r_w;
    assign resp_data      = (|r_resp_valid) ? r_result : '0;

endmodule

// File: tb/tb_sys_array_arbiter.sv
// Directed bench for sys_array_arbiter: the fetcher is emulated inline by the stimulus
// sequence; expected results are hand-computed constants.
module tb_sys_array_arbiter;
    import sys_array_pkg::*;

    localparam int NR = NUM_REQ_DEF;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_reuse_w;
    a_mat_t [NR-1:0]   req_a;
    w_mat_t [NR-1:0]   req_w;
    logic [NR-1:0]     resp_valid;
    logic [NR-1:0]     resp_ready;
    res_mat_t          resp_data;
    logic              resp_timeout;
    logic              f_weights_load;
    logic              f_start_comp;
    a_mat_t            f_input_data;
    w_mat_t            f_weights;
    logic              f_ready;
    res_mat_t          f_out_data;

    w_mat_t            fw;
    int                n_tests = 0;
    int                n_fail  = 0;
    int                cyc;
    int                bad;

    always #5 clk = ~clk;

    sys_array_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_reuse_w    (req_reuse_w),
        .req_a          (req_a),
        .req_w          (req_w),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_timeout   (resp_timeout),
        .f_weights_load (f_weights_load),
        .f_start_comp   (f_start_comp),
        .f_input_data   (f_input_data),
        .f_weights      (f_weights),
        .f_ready        (f_ready),
        .f_out_data     (f_out_data)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic a_mat_t ident();
        a_mat_t m;
        for (int i = 0; i < A_W_DEF; i++)
            for (int k = 0; k < A_L_DEF; k++)
                m[i][k] = (i == k) ? DATA_WIDTH_DEF'(1) : DATA_WIDTH_DEF'(0);
        return m;
    endfunction

    function automatic a_mat_t fill_a(input int v);
        a_mat_t m;
        for (int i = 0; i < A_W_DEF; i++)
            for (int k = 0; k < A_L_DEF; k++) m[i][k] = DATA_WIDTH_DEF'(v);
        return m;
    endfunction

    function automatic w_mat_t fill_w(input int v);
        w_mat_t m;
        for (int k = 0; k < W_W_DEF; k++)
            for (int j = 0; j < W_L_DEF; j++) m[k][j] = DATA_WIDTH_DEF'(v);
        return m;
    endfunction

    function automatic res_mat_t fill_r(input int v);
        res_mat_t m;
        for (int i = 0; i < A_W_DEF; i++)
            for (int j = 0; j < W_L_DEF; j++) m[i][j] = RES_WIDTH_DEF'(v);
        return m;
    endfunction

    // Emulated fetcher arithmetic: product of the presented inputs and the last loaded weights.
    function automatic res_mat_t matmul(input a_mat_t a, input w_mat_t w);
        res_mat_t r;
        int acc;
        r = '0;
        for (int i = 0; i < A_W_DEF; i++)
            for (int j = 0; j < W_L_DEF; j++) begin
                acc = 0;
                for (int k = 0; k < A_L_DEF; k++) acc += $signed(a[i][k]) * $signed(w[k][j]);
                r[i][j] = RES_WIDTH_DEF'(acc);
            end
        return r;
    endfunction

    task automatic do_reset();
        reset_n    = 1'b0;
        req_valid  = '0;
        resp_ready = '0;
        f_ready    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Accept one job, play the fetcher (f_ready 'lat' cycles after start), check the response,
    // hold resp_ready low for ack_delay cycles, then acknowledge.
    task automatic serve(input string tag, input logic [NR-1:0] exp_gnt, input int exp_loads,
                         input res_mat_t exp_res, input int lat, input int exp_lat,
                         input int ack_delay);
        int n, loads, starts, overlap, fire, stale;
        res_mat_t res;
        n = 0;
        while (req_ready == '0 && n < 20) begin @(negedge clk); n++; end
        check({tag, "/grant"}, req_ready, exp_gnt);
        loads = 0; starts = 0; overlap = 0; fire = -1; n = 0; res = '0;
        while (resp_valid == '0 && n < 200) begin
            if (f_weights_load) begin loads++; fw = f_weights; end
            if (f_start_comp) begin
                starts++;
                res  = matmul(f_input_data, fw);
                fire = n + lat;
            end
            if (f_weights_load && f_start_comp) overlap++;
            f_ready    = (n == fire);
            f_out_data = (n == fire) ? res : fill_r(99);
            @(negedge clk);
            n++;
        end
        f_ready    = 1'b0;
        f_out_data = fill_r(99);
        check({tag, "/resp_valid"}, resp_valid, exp_gnt);
        check({tag, "/resp_data"}, resp_data, exp_res);
        check({tag, "/weight_loads"}, loads, exp_loads);
        check({tag, "/starts"}, starts, 1);
        check({tag, "/ctrl_overlap"}, overlap, 0);
        if (exp_lat >= 0) check({tag, "/latency"}, n, exp_lat);
        stale = 0;
        for (int d = 0; d < ack_delay; d++) begin
            resp_ready = ~exp_gnt;
            @(negedge clk);
            if (resp_valid !== exp_gnt || resp_data !== exp_res || req_ready !== '0) stale++;
        end
        if (ack_delay > 0) check({tag, "/backpressure_unstable_cycles"}, stale, 0);
        resp_ready = exp_gnt;
        @(negedge clk);
        resp_ready = '0;
        check({tag, "/resp_valid_after_ack"}, resp_valid, '0);
        check({tag, "/resp_data_zero_after_ack"}, resp_data, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset_n     = 1'b0;
        req_valid   = '0;
        req_reuse_w = '0;
        req_a       = '0;
        req_w       = '0;
        resp_ready  = '0;
        f_ready     = 1'b0;
        f_out_data  = '0;
        fw          = '0;
        repeat (3) @(negedge clk);
        check("reset/req_ready", req_ready, '0);
        check("reset/resp_valid", resp_valid, '0);
        check("reset/resp_timeout", resp_timeout, 1'b0);
        check("reset/f_weights_load", f_weights_load, 1'b0);
        check("reset/f_start_comp", f_start_comp, 1'b0);
        check("reset/resp_data", resp_data, '0);
        check("reset/f_input_data", f_input_data, '0);
        reset_n = 1'b1;

        // Single job: identity x all-2 gives all-2.
        req_a[0] = ident(); req_w[0] = fill_w(2); req_valid = 4'b0001;
        serve("single", 4'b0001, 1, fill_r(2), 1, 3, 0);
        req_valid = '0;

        // Fairness with all requesters held valid.
        do_reset();
        for (int i = 0; i < NR; i++) begin req_a[i] = ident(); req_w[i] = fill_w(i + 1); end
        req_valid = 4'b1111;
        serve("rr0", 4'b0001, 1, fill_r(1), 2, -1, 0);
        serve("rr1", 4'b0010, 1, fill_r(2), 2, -1, 0);
        serve("rr2", 4'b0100, 1, fill_r(3), 2, -1, 0);
        serve("rr3", 4'b1000, 1, fill_r(4), 2, -1, 0);
        serve("rr4", 4'b0001, 1, fill_r(1), 2, -1, 0);
        req_valid = '0;

        // Weight reuse: second job from owner 2 keeps W=3, so all-1 x 3 over 4 terms = 12.
        req_a[2] = ident(); req_w[2] = fill_w(3); req_valid = 4'b0100;
        serve("reuse_first", 4'b0100, 1, fill_r(3), 2, -1, 0);
        req_a[2] = fill_a(1); req_w[2] = fill_w(5); req_reuse_w = 4'b0100;
        serve("reuse_second", 4'b0100, 0, fill_r(12), 2, -1, 0);
        req_valid = '0;
        req_a[1] = ident(); req_w[1] = fill_w(1); req_reuse_w = 4'b0010; req_valid = 4'b0010;
        serve("reuse_non_owner", 4'b0010, 1, fill_r(1), 2, -1, 0);
        req_valid = '0; req_reuse_w = '0;

        // Backpressure with requester 0 waiting; 2 x -1 over 4 terms = -8.
        req_a[3] = fill_a(2); req_w[3] = fill_w(-1);
        req_a[0] = ident();   req_w[0] = fill_w(7);
        req_valid = 4'b1001;
        serve("bp", 4'b1000, 1, fill_r(-8), 3, -1, 10);
        req_valid = 4'b0001;
        serve("bp_next", 4'b0001, 1, fill_r(7), 1, -1, 0);
        req_valid = '0;

        // Timeout: fetcher never answers.
        req_a[1] = ident(); req_w[1] = fill_w(4); req_valid = 4'b0010;
        cyc = 0;
        while (!f_start_comp && cyc < 20) begin @(negedge clk); cyc++; end
        req_valid = '0;
        check("timeout/start_seen", f_start_comp, 1'b1);
        @(negedge clk);
        cyc = 0; bad = 0;
        while (!resp_timeout && cyc < 200) begin
            if (resp_valid != '0) bad++;
            @(negedge clk);
            cyc++;
        end
        check("timeout/cycles_from_wait", cyc, 64);
        check("timeout/no_resp_valid", bad, 0);
        check("timeout/resp_valid_after", resp_valid, '0);
        req_w[1] = fill_w(6); req_reuse_w = 4'b0010; req_valid = 4'b0010;
        serve("after_timeout", 4'b0010, 1, fill_r(6), 2, -1, 0);
        req_valid = '0; req_reuse_w = '0;
        check("timeout/sticky", resp_timeout, 1'b1);

        // Reset while waiting on the fetcher.
        req_a[2] = ident(); req_w[2] = fill_w(2); req_valid = 4'b0100;
        cyc = 0;
        while (!f_start_comp && cyc < 20) begin @(negedge clk); cyc++; end
        req_valid = '0;
        @(negedge clk);
        f_out_data = fill_r(5);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_wait/req_ready", req_ready, '0);
        check("rst_wait/resp_valid", resp_valid, '0);
        check("rst_wait/resp_timeout", resp_timeout, 1'b0);
        check("rst_wait/f_weights_load", f_weights_load, 1'b0);
        check("rst_wait/f_start_comp", f_start_comp, 1'b0);
        check("rst_wait/resp_data", resp_data, '0);
        reset_n = 1'b1;
        f_ready = 1'b1;
        @(negedge clk);
        f_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (resp_valid != '0 || req_ready != '0 || f_start_comp) bad++;
            @(negedge clk);
        end
        check("rst_wait/no_stale_activity", bad, 0);
        req_a[3] = ident(); req_w[3] = fill_w(9); req_reuse_w = 4'b1000; req_valid = 4'b1000;
        serve("after_reset", 4'b1000, 1, fill_r(9), 1, 3, 0);
        req_valid = '0; req_reuse_w = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
